// File: rtl/keypad_digit_collector.sv
// Keypad front end for the lock controller: collects up to six digits, strobes
// the judge, waits for the verdict and enforces a lockout after repeated failures.
module keypad_digit_collector #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int LOCK_CYC    = 5000,
  parameter int MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       res,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d6,
  output logic [2:0] count,
  output logic       j,
  output logic       ok,
  output logic       err,
  output logic       locked,
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    FULL,
    WAIT_RES,
    LOCKOUT
  } state_t;

  localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYC - 1);
  localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAIL);

  state_t state;
  state_t state_nxt;

  // dig[0] holds d1, the first digit keyed in
  logic [5:0][3:0] dig;
  logic [5:0][3:0] dig_nxt;
  logic [2:0]      count_nxt;
  logic            j_nxt;
  logic            ok_nxt;
  logic            err_nxt;
  logic            locked_nxt;
  logic [1:0]      fail_nxt;
  logic [IW-1:0]   idle_cnt;
  logic [IW-1:0]   idle_nxt;
  logic [LW-1:0]   lock_cnt;
  logic [LW-1:0]   lock_nxt;
  logic [1:0]      wait_cnt;
  logic [1:0]      wait_nxt;

  logic       is_digit;
  logic       is_bksp;
  logic       is_enter;
  logic       is_cancel;
  logic       in_edit;
  logic       timeout;
  logic       res_sample;
  logic       lock_done;
  logic [2:0] fail_inc;
  logic       lock_trip;

  assign is_digit  = (key_code <= 4'd9);
  assign is_bksp   = (key_code == 4'hA);
  assign is_enter  = (key_code == 4'hB);
  assign is_cancel = (key_code == 4'hC);

  assign in_edit    = (state == IDLE) || (state == ENTRY) || (state == FULL);
  assign timeout    = ((state == ENTRY) || (state == FULL)) && (idle_cnt == IDLE_LAST);
  assign res_sample = (state == WAIT_RES) && (wait_cnt == 2'd2);
  assign lock_done  = (state == LOCKOUT) && (lock_cnt == LOCK_LAST);
  assign fail_inc   = {1'b0, fail_cnt} + 3'd1;
  assign lock_trip  = !res && (fail_inc == FAIL_LIMIT);

  assign d1 = dig[0];
  assign d2 = dig[1];
  assign d3 = dig[2];
  assign d4 = dig[3];
  assign d5 = dig[4];
  assign d6 = dig[5];

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      dig      <= '0;
      count    <= '0;
      j        <= 1'b0;
      ok       <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
      idle_cnt <= '0;
      lock_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dig      <= dig_nxt;
      count    <= count_nxt;
      j        <= j_nxt;
      ok       <= ok_nxt;
      err      <= err_nxt;
      locked   <= locked_nxt;
      fail_cnt <= fail_nxt;
      idle_cnt <= idle_nxt;
      lock_cnt <= lock_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // A key arriving in the same cycle the inactivity timer expires takes precedence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ENTRY, FULL: begin
        if (key_valid) begin
          if (is_digit) begin
            if (state != FULL) begin
              state_nxt = (count == 3'd5) ? FULL : ENTRY;
            end
          end else if (is_bksp) begin
            if (count != 3'd0) begin
              state_nxt = (count == 3'd1) ? IDLE : ENTRY;
            end
          end else if (is_cancel) begin
            state_nxt = IDLE;
          end else if (is_enter) begin
            if (state == FULL) begin
              state_nxt = WAIT_RES;
            end
          end
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      WAIT_RES: begin
        if (res_sample) begin
          state_nxt = lock_trip ? LOCKOUT : IDLE;
        end
      end
      LOCKOUT: begin
        if (lock_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dig_nxt    = dig;
    count_nxt  = count;
    j_nxt      = 1'b0;
    ok_nxt     = 1'b0;
    err_nxt    = 1'b0;
    fail_nxt   = fail_cnt;
    idle_nxt   = idle_cnt;
    lock_nxt   = lock_cnt;
    wait_nxt   = wait_cnt;
    locked_nxt = (state_nxt == LOCKOUT);
    if (in_edit) begin
      idle_nxt = (state == IDLE) ? '0 : idle_cnt + 1'b1;
      if (key_valid) begin
        idle_nxt = '0;
        if (is_digit) begin
          if (state == FULL) begin
            err_nxt = 1'b1;
          end else begin
            dig_nxt[count] = key_code;
            count_nxt      = count + 3'd1;
          end
        end else if (is_bksp) begin
          if (count == 3'd0) begin
            err_nxt = 1'b1;
          end else begin
            dig_nxt[count - 3'd1] = 4'd0;
            count_nxt             = count - 3'd1;
          end
        end else if (is_cancel) begin
          dig_nxt   = '0;
          count_nxt = 3'd0;
        end else if (is_enter) begin
          if (state == FULL) begin
            j_nxt    = 1'b1;
            wait_nxt = 2'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          err_nxt = 1'b1;
        end
      end else if (timeout) begin
        err_nxt   = 1'b1;
        dig_nxt   = '0;
        count_nxt = 3'd0;
        idle_nxt  = '0;
      end
    end else if (state == WAIT_RES) begin
      wait_nxt = wait_cnt + 2'd1;
      if (res_sample) begin
        dig_nxt   = '0;
        count_nxt = 3'd0;
        wait_nxt  = 2'd0;
        lock_nxt  = '0;
        if (res) begin
          ok_nxt   = 1'b1;
          fail_nxt = 2'd0;
        end else begin
          fail_nxt = fail_inc[1:0];
        end
      end
    end else if (state == LOCKOUT) begin
      lock_nxt = lock_cnt + 1'b1;
      if (lock_done) begin
        lock_nxt = '0;
        fail_nxt = 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_digit_collector.sv
// Directed bench for keypad_digit_collector; j/ok/err strobes are checked by a
// monitor against a queue of expected events filled by the stimulus thread.
module tb_keypad_digit_collector;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_valid;
  logic [3:0] key_code;
  logic       res;
  logic [3:0] d1, d2, d3, d4, d5, d6;
  logic [2:0] count;
  logic       j, ok, err, locked;
  logic [1:0] fail_cnt;

  keypad_digit_collector dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code), .res(res),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .count(count), .j(j), .ok(ok), .err(err), .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] EV_J = 2'd1, EV_OK = 2'd2, EV_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] dig;
    logic [2:0]  cnt;
    logic [1:0]  fail;
  } ev_t;

  ev_t         expQ[$];
  ev_t         actEv;
  ev_t         expEv;
  int          total = 0;
  int          bad = 0;
  int          lockCycles = 0;
  logic [23:0] digAll;

  assign digAll = {d1, d2, d3, d4, d5, d6};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expectEvent(input logic [1:0] kind, input logic [23:0] dig,
                             input logic [2:0] cnt, input logic [1:0] fail);
    ev_t e;
    e.kind = kind;
    e.dig  = dig;
    e.cnt  = cnt;
    e.fail = fail;
    expQ.push_back(e);
  endtask

  // Called aligned to a falling edge; the key is sampled on the next rising edge
  task automatic applyStimulus(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Drives res only in the cycle two after the j cycle
  task automatic answerJudge(input logic r);
    @(negedge clk);
    @(negedge clk);
    res = r;
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic resetDut();
    clr       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    res       = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic runTests();
    resetDut();
    checkOutput("reset_count", count, 0);
    checkOutput("reset_digits", digAll, 0);
    checkOutput("reset_strobes", {j, ok, err, locked}, 0);
    checkOutput("reset_fail_cnt", fail_cnt, 0);

    // accepted code
    expectEvent(EV_J, 24'h123456, 3'd6, 2'd0);
    for (int k = 1; k <= 6; k++) applyStimulus(4'(k));
    checkOutput("full_count", count, 6);
    applyStimulus(4'hB);
    expectEvent(EV_OK, 24'h0, 3'd0, 2'd0);
    answerJudge(1'b1);
    checkOutput("ok_count", count, 0);
    checkOutput("ok_fail_cnt", fail_cnt, 0);

    // backspace editing and short enter
    applyStimulus(4'd7);
    applyStimulus(4'd8);
    applyStimulus(4'hA);
    applyStimulus(4'd9);
    checkOutput("bksp_count", count, 2);
    checkOutput("bksp_digits", digAll, 24'h790000);
    expectEvent(EV_ERR, 24'h790000, 3'd2, 2'd0);
    applyStimulus(4'hB);
    repeat (4) @(negedge clk);
    checkOutput("short_enter_count", count, 2);
    applyStimulus(4'hC);
    checkOutput("cancel_count", count, 0);
    checkOutput("cancel_digits", digAll, 0);

    // empty backspace, illegal code, overflow digit
    expectEvent(EV_ERR, 24'h0, 3'd0, 2'd0);
    applyStimulus(4'hA);
    expectEvent(EV_ERR, 24'h0, 3'd0, 2'd0);
    applyStimulus(4'hE);
    expectEvent(EV_ERR, 24'h123456, 3'd6, 2'd0);
    for (int k = 1; k <= 7; k++) applyStimulus(4'(k));
    checkOutput("overflow_count", count, 6);
    checkOutput("overflow_digits", digAll, 24'h123456);
    applyStimulus(4'hC);

    // inactivity timeout and the key that beats it
    applyStimulus(4'd5);
    expectEvent(EV_ERR, 24'h0, 3'd0, 2'd0);
    repeat (1000) @(negedge clk);
    checkOutput("timeout_count", count, 0);
    applyStimulus(4'd5);
    repeat (999) @(negedge clk);
    applyStimulus(4'd5);
    checkOutput("late_key_count", count, 2);
    repeat (5) @(negedge clk);
    checkOutput("late_key_hold", count, 2);
    applyStimulus(4'hC);

    // repeated failures leading to lockout
    for (int f = 1; f <= 3; f++) begin
      expectEvent(EV_J, 24'h987654, 3'd6, 2'(f - 1));
      for (int k = 9; k >= 4; k--) applyStimulus(4'(k));
      applyStimulus(4'hB);
      answerJudge(1'b0);
      checkOutput("fail_cnt_step", fail_cnt, f);
      checkOutput("locked_step", locked, (f == 3));
      checkOutput("fail_count_zero", count, 0);
    end
    applyStimulus(4'd1);
    applyStimulus(4'hB);
    applyStimulus(4'hE);
    applyStimulus(4'hC);
    checkOutput("lockout_keys_count", count, 0);
    for (int i = 0; i < 6000 && locked === 1'b1; i++) @(negedge clk);
    checkOutput("lock_release", locked, 0);
    checkOutput("lock_cycles", lockCycles, 5000);
    checkOutput("lock_fail_clear", fail_cnt, 0);
    applyStimulus(4'd3);
    checkOutput("post_lock_count", count, 1);
    applyStimulus(4'hC);

    // reset while waiting for the verdict
    expectEvent(EV_J, 24'h246813, 3'd6, 2'd0);
    applyStimulus(4'd2);
    applyStimulus(4'd4);
    applyStimulus(4'd6);
    applyStimulus(4'd8);
    applyStimulus(4'd1);
    applyStimulus(4'd3);
    applyStimulus(4'hB);
    @(negedge clk);
    clr = 1'b1;
    res = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr_digits", digAll, 0);
    checkOutput("clr_count", count, 0);
    checkOutput("clr_strobes", {j, ok, err, locked}, 0);
    checkOutput("clr_fail_cnt", fail_cnt, 0);
    repeat (4) @(negedge clk);
    res = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pending_events", expQ.size(), 0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          if (locked === 1'b1) lockCycles++;
          if (j === 1'b1 || ok === 1'b1 || err === 1'b1) begin
            actEv.kind = j ? EV_J : (ok ? EV_OK : EV_ERR);
            actEv.dig  = digAll;
            actEv.cnt  = count;
            actEv.fail = fail_cnt;
            checkOutput("single_strobe", $countones({j, ok, err}), 1);
            total++;
            if (expQ.size() == 0) begin
              bad++;
              $display("[TB] FAIL unexpected_event actual kind=%0d dig=%h cnt=%0d fail=%0d expected none",
                       actEv.kind, actEv.dig, actEv.cnt, actEv.fail);
            end else begin
              expEv = expQ.pop_front();
              if (actEv !== expEv) begin
                bad++;
                $display("[TB] FAIL event actual kind=%0d dig=%h cnt=%0d fail=%0d expected kind=%0d dig=%h cnt=%0d fail=%0d",
                         actEv.kind, actEv.dig, actEv.cnt, actEv.fail,
                         expEv.kind, expEv.dig, expEv.cnt, expEv.fail);
              end
            end
          end
        end
      end
      runTests();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
